bp_resolve_queue: RTL



---
 rtl/bp_resolve_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-side branch predictions, popped on resolution to train the predictor.
// Define BP_STATS_EN to build the saturating total/miss statistics counters.
module bp_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_ready,
    input  logic             flush,
    output logic             upd_valid,
    output logic             upd_result,
    output logic             mispredict,
    output logic [PTR_W:0]   occupancy,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_result_q, upd_result_d;
    logic             mispredict_q, mispredict_d;
    logic             push, pop;

    assign pred_ready = (occ_q != FULL);
    assign res_ready  = (occ_q != '0);
    assign push       = pred_valid && pred_ready && !flush;
    assign pop        = res_valid && res_ready && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        upd_valid_d  = 1'b0;
        mispredict_d = 1'b0;
        upd_result_d = upd_result_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                upd_valid_d  = 1'b1;
                upd_result_d = res_taken;
                mispredict_d = res_taken ^ mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            upd_valid_q  <= 1'b0;
            upd_result_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            upd_valid_q  <= upd_valid_d;
            upd_result_q <= upd_result_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pred_taken;
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_result = upd_result_q;
    assign mispredict = mispredict_q;
    assign occupancy  = occ_q;

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    always_comb begin
        total_d = total_q;
        miss_d  = miss_q;
        if (pop) begin
            if (total_q != '1) begin
                total_d = total_q + 1'b1;
            end
            if ((res_taken ^ mem_q[rd_ptr_q]) && (miss_q != '1)) begin
                miss_d = miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            miss_q  <= '0;
        end else begin
            total_q <= total_d;
            miss_q  <= miss_d;
        end
    end

    assign total_cnt = total_q;
    assign miss_cnt  = miss_q;
`else
    assign total_cnt = '0;
    assign miss_cnt  = '0;
`endif

endmodule
